// File: rtl/hdmi_video_pkg.sv
// Shared definitions for the HDMI line-buffer read path: line FSM encodings
// and raster-size helpers used to size the timing counters.
package hdmi_video_pkg;

    typedef logic [1:0] line_state_t;

    localparam line_state_t ST_IDLE  = 2'd0;
    localparam line_state_t ST_READ  = 2'd1;
    localparam line_state_t ST_BLACK = 2'd2;

    function automatic int h_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int v_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // Bits needed to count 0..total-1; never less than one.
    function automatic int clog2(input int total);
        int w;
        w = 1;
        while ((1 << w) < total) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/hdmi_linebuf_reader_if.sv
// Signal bundle between the line-buffer reader, the line RAM read port,
// the line writer handshake and the HDMI TX video input.
interface hdmi_linebuf_reader_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 24
);

    logic                  line_ready;
    logic                  line_ack;
    logic                  frame_start;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  vid_hs;
    logic                  vid_vs;
    logic                  vid_de;
    logic [DATA_WIDTH-1:0] vid_data;
    logic                  underflow;

    modport master (
        input  line_ready,
        input  rd_data,
        output line_ack,
        output frame_start,
        output rd_addr,
        output vid_hs,
        output vid_vs,
        output vid_de,
        output vid_data,
        output underflow
    );

    modport slave (
        output line_ready,
        output rd_data,
        input  line_ack,
        input  frame_start,
        input  rd_addr,
        input  vid_hs,
        input  vid_vs,
        input  vid_de,
        input  vid_data,
        input  underflow
    );

endinterface

// File: rtl/hdmi_timing_cnt.sv
// Raster position counters and the raw (unpipelined) decodes of the current
// position: active area, line start/last pixel, frame origin, hsync, vsync.
module hdmi_timing_cnt
    import hdmi_video_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HW       = clog2(h_total(H_ACTIVE, H_FP, H_SYNC, H_BP))
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    output logic [HW-1:0] o_h_cnt,
    output logic          o_active,
    output logic          o_line_start,
    output logic          o_line_last,
    output logic          o_origin,
    output logic          o_hs_raw,
    output logic          o_vs_raw
);

    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int VW      = clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_ACT_LAST = HW'(H_ACTIVE - 1);
    localparam logic [HW-1:0] HS_FIRST   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_LAST    = HW'(H_ACTIVE + H_FP + H_SYNC - 1);

    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_FIRST   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_LAST    = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [HW-1:0] r_h_cnt;
    logic [VW-1:0] r_v_cnt;
    logic          w_h_act;
    logic          w_v_act;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == H_LAST) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 1'b1;
        end else begin
            r_h_cnt <= r_h_cnt + 1'b1;
        end
    end

    assign w_h_act      = (r_h_cnt < H_ACT);
    assign w_v_act      = (r_v_cnt < V_ACT);

    assign o_h_cnt      = r_h_cnt;
    assign o_active     = w_h_act && w_v_act;
    assign o_line_start = (r_h_cnt == '0) && w_v_act;
    assign o_line_last  = (r_h_cnt == H_ACT_LAST) && w_v_act;
    assign o_origin     = (r_h_cnt == '0) && (r_v_cnt == '0);
    assign o_hs_raw     = (r_h_cnt >= HS_FIRST) && (r_h_cnt <= HS_LAST);
    assign o_vs_raw     = (r_v_cnt >= VS_FIRST) && (r_v_cnt <= VS_LAST);

endmodule

// File: rtl/hdmi_linebuf_reader.sv
// HDMI raster generator that streams one line per active line out of the
// line RAM, with line ownership handed back to the writer via line_ack.
module hdmi_linebuf_reader
    import hdmi_video_pkg::*;
#(
    parameter int   H_ACTIVE   = 640,
    parameter int   H_FP       = 16,
    parameter int   H_SYNC     = 96,
    parameter int   H_BP       = 48,
    parameter int   V_ACTIVE   = 480,
    parameter int   V_FP       = 10,
    parameter int   V_SYNC     = 2,
    parameter int   V_BP       = 33,
    parameter logic HS_POL     = 1'b0,
    parameter logic VS_POL     = 1'b0,
    parameter int   ADDR_WIDTH = 10,
    parameter int   DATA_WIDTH = 24
) (
    input  logic                 rd_clk,
    input  logic                 rd_rst_n,
    hdmi_linebuf_reader_if.master bus
);

    localparam int HW = clog2(h_total(H_ACTIVE, H_FP, H_SYNC, H_BP));

    logic [HW-1:0]         w_h_cnt;
    logic                  w_active;
    logic                  w_line_start;
    logic                  w_line_last;
    logic                  w_origin;
    logic                  w_hs_raw;
    logic                  w_vs_raw;

    line_state_t           r_state;
    line_state_t           w_state_cur;
    line_state_t           w_state_nxt;
    logic                  w_underflow;
    logic                  w_ack;

    logic [ADDR_WIDTH-1:0] r_rd_addr_p1;
    logic                  r_line_ack_p1;
    logic                  r_underflow_p1;
    logic                  r_frame_start_p1;
    line_state_t           r_state_p1;
    logic                  vld_p1;
    logic                  r_hs_p1;
    logic                  r_vs_p1;

    line_state_t           r_state_p2;
    logic                  vld_p2;
    logic                  r_hs_p2;
    logic                  r_vs_p2;
    logic [DATA_WIDTH-1:0] w_pix_p2;

    hdmi_timing_cnt #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .HW       (HW)
    ) u_timing (
        .i_clk        (rd_clk),
        .i_rst_n      (rd_rst_n),
        .o_h_cnt      (w_h_cnt),
        .o_active     (w_active),
        .o_line_start (w_line_start),
        .o_line_last  (w_line_last),
        .o_origin     (w_origin),
        .o_hs_raw     (w_hs_raw),
        .o_vs_raw     (w_vs_raw)
    );

    // w_state_cur is the line mode that applies to the pixel at the current
    // position, so the line-start decision already covers pixel 0.
    always_comb begin
        w_state_cur = r_state;
        w_underflow = 1'b0;
        if (w_line_start && (r_state == ST_IDLE)) begin
            w_state_cur = bus.line_ready ? ST_READ : ST_BLACK;
            w_underflow = ~bus.line_ready;
        end
        w_ack       = w_line_last && (w_state_cur == ST_READ);
        w_state_nxt = (w_line_last && (w_state_cur != ST_IDLE)) ? ST_IDLE : w_state_cur;
    end

    always_ff @(posedge rd_clk) begin
        if (!rd_rst_n) begin
            r_state          <= ST_IDLE;
            r_rd_addr_p1     <= '0;
            r_line_ack_p1    <= 1'b0;
            r_underflow_p1   <= 1'b0;
            r_frame_start_p1 <= 1'b0;
            r_state_p1       <= ST_IDLE;
            vld_p1           <= 1'b0;
            r_hs_p1          <= ~HS_POL;
            r_vs_p1          <= ~VS_POL;
            r_state_p2       <= ST_IDLE;
            vld_p2           <= 1'b0;
            r_hs_p2          <= ~HS_POL;
            r_vs_p2          <= ~VS_POL;
        end else begin
            r_state          <= w_state_nxt;
            // S1: position-derived controls and the RAM read address
            r_rd_addr_p1     <= w_active ? ADDR_WIDTH'(w_h_cnt) : '0;
            r_line_ack_p1    <= w_ack;
            r_underflow_p1   <= w_underflow;
            r_frame_start_p1 <= w_origin;
            r_state_p1       <= w_state_cur;
            vld_p1           <= w_active;
            r_hs_p1          <= w_hs_raw ? HS_POL : ~HS_POL;
            r_vs_p1          <= w_vs_raw ? VS_POL : ~VS_POL;
            // S2: video timing, aligned with the RAM data for the S1 address
            r_state_p2       <= r_state_p1;
            vld_p2           <= vld_p1;
            r_hs_p2          <= r_hs_p1;
            r_vs_p2          <= r_vs_p1;
        end
    end

    // The RAM's own read register is the S2 data stage; only the mux follows it.
    assign w_pix_p2        = ((r_state_p2 == ST_READ) && vld_p2) ? bus.rd_data : '0;

    assign bus.rd_addr     = r_rd_addr_p1;
    assign bus.line_ack    = r_line_ack_p1;
    assign bus.underflow   = r_underflow_p1;
    assign bus.frame_start = r_frame_start_p1;
    assign bus.vid_hs      = r_hs_p2;
    assign bus.vid_vs      = r_vs_p2;
    assign bus.vid_de      = vld_p2;
    assign bus.vid_data    = w_pix_p2;

endmodule

// File: tb/tb_hdmi_linebuf_reader.sv
// Self-checking bench for hdmi_linebuf_reader on a 14x7 raster with a
// 1-cycle-latency line RAM holding 0x100000+address.
module tb_hdmi_linebuf_reader;

    localparam int HA  = 8;
    localparam int HF  = 2;
    localparam int HSY = 2;
    localparam int HB  = 2;
    localparam int VA  = 4;
    localparam int VF  = 1;
    localparam int VSY = 1;
    localparam int VB  = 1;
    localparam int HT  = HA + HF + HSY + HB;
    localparam int VT  = VA + VF + VSY + VB;
    localparam int FT  = HT * VT;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;
    int   n;
    bit   kind [0:4095];

    hdmi_linebuf_reader_if #(.ADDR_WIDTH(10), .DATA_WIDTH(24)) bus ();

    hdmi_linebuf_reader #(
        .H_ACTIVE   (HA),
        .H_FP       (HF),
        .H_SYNC     (HSY),
        .H_BP       (HB),
        .V_ACTIVE   (VA),
        .V_FP       (VF),
        .V_SYNC     (VSY),
        .V_BP       (VB),
        .HS_POL     (1'b0),
        .VS_POL     (1'b0),
        .ADDR_WIDTH (10),
        .DATA_WIDTH (24)
    ) dut (
        .rd_clk   (clk),
        .rd_rst_n (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Line RAM: address k holds 0x100000+k, one cycle read latency.
    always @(posedge clk) bus.rd_data <= 24'h100000 + 24'(bus.rd_addr);

    // n = raster cycles since the last reset release (0 = counters at (0,0)).
    initial n = 0;
    always @(posedge clk) begin
        if (!rst_n) n <= 0;
        else        n <= n + 1;
    end

    // Record per raster line whether it was started with a line ready.
    always @(negedge clk) begin
        if (rst_n && ((n % HT) == 0) && (((n / HT) % VT) < VA))
            kind[n / HT] <= bus.line_ready;
    end

    // Expected {frame_start, line_ack, underflow, rd_addr, hs, vs, de, data}
    // for raster cycle cyc: S1 outputs describe position cyc-1, video cyc-2.
    function automatic logic [39:0] model_exp(input int cyc);
        logic fs, ack, uf, hs, vs, de;
        logic [9:0]  addr;
        logic [23:0] data;
        int p, h, v, ln;
        fs = 0; ack = 0; uf = 0; hs = 1; vs = 1; de = 0;
        addr = '0; data = '0;
        if (cyc >= 1) begin
            p  = cyc - 1;
            h  = p % HT;
            v  = (p / HT) % VT;
            ln = p / HT;
            fs = ((p % FT) == 0);
            if (h < HA && v < VA) begin
                addr = 10'(h);
                uf   = (h == 0) && !kind[ln];
                ack  = (h == HA - 1) && kind[ln];
            end
        end
        if (cyc >= 2) begin
            p  = cyc - 2;
            h  = p % HT;
            v  = (p / HT) % VT;
            ln = p / HT;
            de = (h < HA) && (v < VA);
            hs = !((h >= HA + HF) && (h < HA + HF + HSY));
            vs = !((v >= VA + VF) && (v < VA + VF + VSY));
            if (de && kind[ln]) data = 24'h100000 + 24'(h);
        end
        return {fs, ack, uf, addr, hs, vs, de, data};
    endfunction

    function automatic logic [39:0] obs();
        return {bus.frame_start, bus.line_ack, bus.underflow, bus.rd_addr,
                bus.vid_hs, bus.vid_vs, bus.vid_de, bus.vid_data};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic restart();
        rst_n = 1'b0;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [39:0] o;
        rst_n = 1'b0;
        bus.line_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            next_cycle();
            @(negedge clk);
            o = obs();
            n_cmp++;
            if (o !== {1'b0, 1'b0, 1'b0, 10'd0, 1'b1, 1'b1, 1'b0, 24'd0}) begin
                n_bad++;
                $display("FAIL reset c=%0d got=%h exp=%h", c, o, {1'b0, 1'b0, 1'b0, 10'd0, 1'b1, 1'b1, 1'b0, 24'd0});
            end
        end
    endtask

    task automatic test_latency();
        bus.line_ready = 1'b1;
        restart();
        @(negedge clk);
        n_cmp++;
        if (bus.frame_start !== 1'b0 || bus.vid_de !== 1'b0) begin
            n_bad++;
            $display("FAIL latency_c0 got fs=%b de=%b exp fs=0 de=0", bus.frame_start, bus.vid_de);
        end
        next_cycle();
        @(negedge clk);
        n_cmp++;
        if (bus.frame_start !== 1'b1 || bus.rd_addr !== 10'd0 || bus.vid_de !== 1'b0) begin
            n_bad++;
            $display("FAIL latency_c1 got fs=%b addr=%h de=%b exp fs=1 addr=0 de=0",
                     bus.frame_start, bus.rd_addr, bus.vid_de);
        end
        next_cycle();
        @(negedge clk);
        n_cmp++;
        if (bus.vid_de !== 1'b1 || bus.vid_data !== 24'h100000 || bus.rd_addr !== 10'd1) begin
            n_bad++;
            $display("FAIL latency_c2 got de=%b data=%h addr=%h exp de=1 data=100000 addr=1",
                     bus.vid_de, bus.vid_data, bus.rd_addr);
        end
    endtask

    task automatic test_full_frame();
        logic [39:0] o, e;
        int acks, fs1, fs2, hs_lo, vs_lo, de_ok;
        acks = 0; fs1 = -1; fs2 = -1; hs_lo = 0; vs_lo = 0; de_ok = 0;
        bus.line_ready = 1'b1;
        restart();
        for (int c = 0; c < 2 * FT + 4; c++) begin
            if (c > 0) next_cycle();
            @(negedge clk);
            o = obs();
            e = model_exp(n);
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL full_frame n=%0d got=%h exp=%h", n, o, e);
            end
            if (n >= 1 && n <= FT && bus.line_ack === 1'b1) acks++;
            if (bus.frame_start === 1'b1) begin
                if (fs1 < 0) fs1 = n;
                else if (fs2 < 0) fs2 = n;
            end
            if (n >= 2 && n < FT + 2) begin
                if (bus.vid_hs === 1'b0) hs_lo++;
                if (bus.vid_vs === 1'b0) vs_lo++;
                if (bus.vid_de === 1'b1 && bus.vid_data === 24'h100000 + 24'((n - 2) % HT)) de_ok++;
            end
        end
        n_cmp++;
        if (acks != VA) begin
            n_bad++;
            $display("FAIL frame_acks got=%0d exp=%0d", acks, VA);
        end
        n_cmp++;
        if (fs1 != 1 || fs2 - fs1 != FT) begin
            n_bad++;
            $display("FAIL frame_start_period got first=%0d period=%0d exp first=1 period=%0d", fs1, fs2 - fs1, FT);
        end
        n_cmp++;
        if (hs_lo != HSY * VT || vs_lo != HT * VSY) begin
            n_bad++;
            $display("FAIL sync_widths got hs_lo=%0d vs_lo=%0d exp %0d %0d", hs_lo, vs_lo, HSY * VT, HT * VSY);
        end
        n_cmp++;
        if (de_ok != HA * VA) begin
            n_bad++;
            $display("FAIL frame_pixels got=%0d exp=%0d", de_ok, HA * VA);
        end
    endtask

    task automatic test_underflow();
        logic [39:0] o, e;
        int ufs, acks, black;
        ufs = 0; acks = 0; black = 0;
        bus.line_ready = 1'b1;
        restart();
        for (int c = 0; c < 64; c++) begin
            if (c > 0) next_cycle();
            if (c == 28) bus.line_ready = 1'b0;
            if (c == 29) bus.line_ready = 1'b1;
            @(negedge clk);
            o = obs();
            e = model_exp(n);
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL underflow n=%0d got=%h exp=%h", n, o, e);
            end
            if (bus.underflow === 1'b1) ufs++;
            if (bus.line_ack === 1'b1) acks++;
            if (bus.vid_de === 1'b1 && bus.vid_data === 24'h0) black++;
        end
        n_cmp++;
        if (ufs != 1 || acks != 3 || black != HA) begin
            n_bad++;
            $display("FAIL underflow_counts got uf=%0d ack=%0d black=%0d exp 1 3 %0d", ufs, acks, black, HA);
        end
    endtask

    task automatic test_late_ready();
        logic [39:0] o, e;
        int ufs, acks, black;
        ufs = 0; acks = 0; black = 0;
        bus.line_ready = 1'b1;
        restart();
        for (int c = 0; c < 64; c++) begin
            if (c > 0) next_cycle();
            if (c == 14) bus.line_ready = 1'b0;
            if (c == 17) bus.line_ready = 1'b1;
            @(negedge clk);
            o = obs();
            e = model_exp(n);
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL late_ready n=%0d got=%h exp=%h", n, o, e);
            end
            if (bus.underflow === 1'b1) ufs++;
            if (bus.line_ack === 1'b1) acks++;
            if (bus.vid_de === 1'b1 && bus.vid_data === 24'h0) black++;
        end
        n_cmp++;
        if (ufs != 1 || acks != 3 || black != HA) begin
            n_bad++;
            $display("FAIL late_ready_counts got uf=%0d ack=%0d black=%0d exp 1 3 %0d", ufs, acks, black, HA);
        end
    endtask

    task automatic test_reset_midline();
        logic [39:0] o, e;
        int acks, fs_cnt, fs_at;
        acks = 0; fs_cnt = 0; fs_at = -1;
        bus.line_ready = 1'b1;
        restart();
        for (int c = 0; c < 40; c++) begin
            if (c > 0) next_cycle();
            if (c == 18) rst_n = 1'b0;
            if (c == 20) rst_n = 1'b1;
            @(negedge clk);
            o = obs();
            e = model_exp(n);
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL reset_midline c=%0d got=%h exp=%h", c, o, e);
            end
            if (c >= 18 && c < 28) begin
                if (bus.line_ack === 1'b1) acks++;
                if (bus.frame_start === 1'b1) begin
                    fs_cnt++;
                    fs_at = c;
                end
            end
        end
        n_cmp++;
        if (acks != 0 || fs_cnt != 1 || fs_at != 21) begin
            n_bad++;
            $display("FAIL reset_midline_events got ack=%0d fs=%0d fs_at=%0d exp 0 1 21", acks, fs_cnt, fs_at);
        end
    endtask

    task automatic test_random();
        logic [39:0] o, e;
        int events;
        events = 0;
        bus.line_ready = 1'b1;
        restart();
        for (int c = 0; c < 3 * FT + 4; c++) begin
            if (c > 0) next_cycle();
            bus.line_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            o = obs();
            e = model_exp(n);
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL random n=%0d got=%h exp=%h", n, o, e);
            end
            if (n >= 1 && n <= 3 * FT && (bus.line_ack === 1'b1 || bus.underflow === 1'b1)) events++;
        end
        n_cmp++;
        if (events != 3 * VA) begin
            n_bad++;
            $display("FAIL random_line_events got=%0d exp=%0d", events, 3 * VA);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        bus.line_ready = 1'b0;
        test_reset();
        test_latency();
        test_full_frame();
        test_underflow();
        test_late_ready();
        test_reset_midline();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
